// File: rtl/aes_bus_master.sv
// aes_bus_master
//   Bus initiator for the register-mapped AES peripheral. Takes one key/block/direction
//   request on a valid/ready stream, runs the register sequence (config, key load, init,
//   block load, next, result read) and returns the 128-bit result on a valid/ready stream.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake (ready only in IDLE)
//   req_key_i, req_block_i    128-bit key / block, word 0 in bits 127:96
//   req_encdec_i              1 = encrypt, 0 = decrypt
//   resp_valid_o/resp_ready_i response handshake
//   resp_data_o, resp_err_o   result (RESULT0 in bits 127:96), timeout flag
//   busy_o                    high whenever not IDLE
//   cs_o, we_o, addr_o,       peripheral register bus; rdata_i is combinational and
//   wdata_o, rdata_i          sampled in the same cycle as a read access
//
// Optional build macro: AES_MASTER_KEY_CACHE_EN
//   Keeps the last successfully initialised key; a request with the same key skips the
//   key load and init phases.

module aes_bus_master #(
    parameter int unsigned POST_WAIT = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] req_key_i,
    input  logic [127:0] req_block_i,
    input  logic         req_encdec_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic [127:0] resp_data_o,
    output logic         resp_err_o,
    output logic         busy_o,
    output logic         cs_o,
    output logic         we_o,
    output logic [7:0]   addr_o,
    output logic [31:0]  wdata_o,
    input  logic [31:0]  rdata_i
);

    // Peripheral register map and control bit positions.
    localparam logic [7:0]  ADDR_CTRL       = 8'h08;
    localparam logic [7:0]  ADDR_STATUS     = 8'h09;
    localparam logic [7:0]  ADDR_CONFIG     = 8'h0a;
    localparam logic [7:0]  ADDR_KEY0       = 8'h10;
    localparam logic [7:0]  ADDR_BLOCK0     = 8'h20;
    localparam logic [7:0]  ADDR_RESULT0    = 8'h30;
    localparam int unsigned CTRL_INIT_BIT   = 0;
    localparam int unsigned CTRL_NEXT_BIT   = 1;
    localparam int unsigned CTRL_ENCDEC_BIT = 2;

    localparam int unsigned WaitW = (POST_WAIT > 1) ? $clog2(POST_WAIT) : 1;
    localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((POST_WAIT > 0) ? POST_WAIT - 1 : 0);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        StIdle, StWrCfg, StWrKey, StInit, StInitWait, StPollInit,
        StWrBlk, StNext, StNextWait, StPollNext, StRdRes, StResp
    } state_e;

    state_e            state_q, state_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      block_q, block_d;
    logic              encdec_q, encdec_d;
    logic [1:0]        word_q, word_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [127:0]      res_q, res_d;
    logic              err_q, err_d;
`ifdef AES_MASTER_KEY_CACHE_EN
    logic [127:0]      last_key_q, last_key_d;
    logic              key_valid_q, key_valid_d;
`endif

    // Word slot 0 of a 128-bit vector sits in bits 127:96.
    logic [6:0] word_lsb;
    assign word_lsb = {~word_q, 5'd0};

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        block_d  = block_q;
        encdec_d = encdec_q;
        word_d   = word_q;
        wait_d   = wait_q;
        tmo_d    = tmo_q;
        res_d    = res_q;
        err_d    = err_q;
`ifdef AES_MASTER_KEY_CACHE_EN
        last_key_d  = last_key_q;
        key_valid_d = key_valid_q;
`endif
        cs_o    = 1'b0;
        we_o    = 1'b0;
        addr_o  = 8'h00;
        wdata_o = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    key_d    = req_key_i;
                    block_d  = req_block_i;
                    encdec_d = req_encdec_i;
                    res_d    = '0;
                    err_d    = 1'b0;
                    word_d   = 2'd0;
                    state_d  = StWrCfg;
                end
            end
            StWrCfg: begin
                cs_o = 1'b1;
                we_o = 1'b1;
                addr_o = ADDR_CONFIG;
                wdata_o[CTRL_ENCDEC_BIT] = encdec_q;
                word_d = 2'd0;
`ifdef AES_MASTER_KEY_CACHE_EN
                state_d = (key_valid_q && key_q == last_key_q) ? StWrBlk : StWrKey;
`else
                state_d = StWrKey;
`endif
            end
            StWrKey: begin
                cs_o    = 1'b1;
                we_o    = 1'b1;
                addr_o  = ADDR_KEY0 + {6'd0, word_q};
                wdata_o = key_q[word_lsb +: 32];
                word_d  = word_q + 2'd1;
                if (word_q == 2'd3) state_d = StInit;
            end
            StInit: begin
                cs_o = 1'b1;
                we_o = 1'b1;
                addr_o = ADDR_CTRL;
                wdata_o[CTRL_INIT_BIT] = 1'b1;
                wait_d  = '0;
                tmo_d   = '0;
                state_d = (POST_WAIT == 0) ? StPollInit : StInitWait;
            end
            StInitWait: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WaitLast) state_d = StPollInit;
            end
            StPollInit: begin
                cs_o   = 1'b1;
                addr_o = ADDR_STATUS;
                if (rdata_i[0]) begin
                    word_d  = 2'd0;
                    state_d = StWrBlk;
`ifdef AES_MASTER_KEY_CACHE_EN
                    last_key_d  = key_q;
                    key_valid_d = 1'b1;
`endif
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = StResp;
`ifdef AES_MASTER_KEY_CACHE_EN
                    key_valid_d = 1'b0;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWrBlk: begin
                cs_o    = 1'b1;
                we_o    = 1'b1;
                addr_o  = ADDR_BLOCK0 + {6'd0, word_q};
                wdata_o = block_q[word_lsb +: 32];
                word_d  = word_q + 2'd1;
                if (word_q == 2'd3) state_d = StNext;
            end
            StNext: begin
                cs_o = 1'b1;
                we_o = 1'b1;
                addr_o = ADDR_CTRL;
                wdata_o[CTRL_NEXT_BIT] = 1'b1;
                wait_d  = '0;
                tmo_d   = '0;
                state_d = (POST_WAIT == 0) ? StPollNext : StNextWait;
            end
            StNextWait: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WaitLast) state_d = StPollNext;
            end
            StPollNext: begin
                cs_o   = 1'b1;
                addr_o = ADDR_STATUS;
                if (rdata_i[1] && rdata_i[0]) begin
                    word_d  = 2'd0;
                    state_d = StRdRes;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = StResp;
`ifdef AES_MASTER_KEY_CACHE_EN
                    key_valid_d = 1'b0;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRdRes: begin
                cs_o   = 1'b1;
                addr_o = ADDR_RESULT0 + {6'd0, word_q};
                res_d[word_lsb +: 32] = rdata_i;
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) state_d = StResp;
            end
            StResp: begin
                if (resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            key_q    <= '0;
            block_q  <= '0;
            encdec_q <= 1'b0;
            word_q   <= '0;
            wait_q   <= '0;
            tmo_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
`ifdef AES_MASTER_KEY_CACHE_EN
            last_key_q  <= '0;
            key_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            block_q  <= block_d;
            encdec_q <= encdec_d;
            word_q   <= word_d;
            wait_q   <= wait_d;
            tmo_q    <= tmo_d;
            res_q    <= res_d;
            err_q    <= err_d;
`ifdef AES_MASTER_KEY_CACHE_EN
            last_key_q  <= last_key_d;
            key_valid_q <= key_valid_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_data_o  = res_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_aes_bus_master.sv
// Directed bench for aes_bus_master against a behavioural AES register-file stub.
// The stub stores key/block/config, models init/next busy time with a registered status,
// and returns the known FIPS-197 ciphertext/plaintext for the reference key.

module tb_aes_bus_master;

    localparam int unsigned PW  = 2;
    localparam int unsigned TMO = 16;
    localparam int INIT_LAT = 4;  // stub busy cycles after INIT -> 3 polls with PW=2
    localparam int NEXT_LAT = 6;  // stub busy cycles after NEXT -> 5 polls with PW=2

    localparam logic [7:0] A_CTRL = 8'h08, A_STATUS = 8'h09, A_CONFIG = 8'h0a;
    localparam logic [7:0] A_KEY0 = 8'h10, A_BLK0 = 8'h20, A_RES0 = 8'h30;

    localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C  = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam int LAT_FULL = 28;  // 16 access/handshake cycles + 2*PW + 3 + 5 polls
    localparam int LAT_HIT  = 18;  // LAT_FULL - (5 + PW + 3)
`ifdef AES_MASTER_KEY_CACHE_EN
    localparam int LAT_BP = LAT_HIT;
`else
    localparam int LAT_BP = LAT_FULL;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] req_key = '0;
    logic [127:0] req_block = '0;
    logic         req_encdec = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [127:0] resp_data;
    logic         resp_err;
    logic         busy;
    logic         cs, we;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_bus_master #(
        .POST_WAIT (PW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_key_i    (req_key),
        .req_block_i  (req_block),
        .req_encdec_i (req_encdec),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .busy_o       (busy),
        .cs_o         (cs),
        .we_o         (we),
        .addr_o       (addr),
        .wdata_o      (wdata),
        .rdata_i      (rdata)
    );

    // ---------------- peripheral stub ----------------
    logic [127:0] st_key = '0;
    logic [127:0] st_blk = '0;
    logic [31:0]  st_cfg = '0;
    int           st_cnt = 0;
    logic         st_ready = 1'b1;
    logic         st_valid = 1'b0;
    logic         st_isnext = 1'b0;
    logic [127:0] st_res = '0;
    logic         stuck = 1'b0;

    function automatic logic [127:0] calc(input logic [127:0] k, input logic [127:0] b,
                                          input logic enc);
        if (k == K && b == P && enc) return C;
        if (k == K && b == C && !enc) return P;
        return 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    endfunction

    always @(posedge clk) begin
        if (cs && we) begin
            if (addr[7:2] == A_KEY0[7:2]) st_key[{~addr[1:0], 5'd0} +: 32] <= wdata;
            if (addr[7:2] == A_BLK0[7:2]) st_blk[{~addr[1:0], 5'd0} +: 32] <= wdata;
            if (addr == A_CONFIG) st_cfg <= wdata;
            if (addr == A_CTRL && wdata[0]) begin
                st_cnt <= INIT_LAT; st_ready <= 1'b0; st_isnext <= 1'b0;
            end else if (addr == A_CTRL && wdata[1]) begin
                st_cnt <= NEXT_LAT; st_ready <= 1'b0; st_valid <= 1'b0; st_isnext <= 1'b1;
            end
        end else if (st_cnt != 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) begin
                st_ready <= 1'b1;
                if (st_isnext) begin
                    st_valid <= 1'b1;
                    st_res   <= calc(st_key, st_blk, st_cfg[2]);
                end
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (cs && !we) begin
            if (addr == A_STATUS) rdata = stuck ? 32'h0 : {30'h0, st_valid, st_ready};
            else if (addr[7:2] == A_RES0[7:2]) rdata = st_res[{~addr[1:0], 5'd0} +: 32];
        end
    end

    // ---------------- bus monitor ----------------
    logic [7:0]  wr_addr [256];
    logic [31:0] wr_data [256];
    int wr_n = 0, stat_n = 0, res_n = 0, viol_n = 0;

    always @(posedge clk) begin
        if (cs && we && wr_n < 256) begin
            wr_addr[wr_n] <= addr;
            wr_data[wr_n] <= wdata;
            wr_n <= wr_n + 1;
        end
        if (cs && !we && addr == A_STATUS) stat_n <= stat_n + 1;
        if (cs && !we && addr[7:2] == A_RES0[7:2]) res_n <= res_n + 1;
        if (!cs && (we || addr != 8'h0 || wdata != 32'h0)) viol_n <= viol_n + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns cycles from accept cycle T to first resp_valid_o.
    // With junk=1 the request inputs are scrambled but kept valid after acceptance.
    task automatic do_req(input logic [127:0] key, input logic [127:0] blk, input logic enc,
                          input bit junk, output int lat);
        int n;
        req_key = key; req_block = blk; req_encdec = enc; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        if (junk) begin
            req_key = ~key; req_block = ~blk; req_encdec = ~enc;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        req_valid = 1'b0;
    endtask

    logic [7:0]  exp_a [11];
    logic [31:0] exp_d [11];
    int lat, wb, sb, rb, n;

    initial begin
        exp_a[0] = A_CONFIG;   exp_d[0] = 32'h4;
        for (int i = 0; i < 4; i++) begin
            exp_a[1 + i] = A_KEY0 + 8'(i); exp_d[1 + i] = K[(3 - i) * 32 +: 32];
            exp_a[6 + i] = A_BLK0 + 8'(i); exp_d[6 + i] = P[(3 - i) * 32 +: 32];
        end
        exp_a[5] = A_CTRL;  exp_d[5] = 32'h1;
        exp_a[10] = A_CTRL; exp_d[10] = 32'h2;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'd1);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_cs", 128'(cs), 128'd0);
        chk("rst_we", 128'(we), 128'd0);
        chk("rst_addr", 128'(addr), 128'd0);
        chk("rst_wdata", 128'(wdata), 128'd0);
        chk("rst_resp_data", resp_data, 128'd0);
        chk("rst_resp_err", 128'(resp_err), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic encrypt with full bus trace
        wb = wr_n; sb = stat_n; rb = res_n;
        do_req(K, P, 1'b1, 1'b0, lat);
        chk("enc_latency", 128'(lat), 128'(LAT_FULL));
        chk("enc_data", resp_data, C);
        chk("enc_err", 128'(resp_err), 128'd0);
        chk("enc_writes", 128'(wr_n - wb), 128'd11);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("enc_wr_addr%0d", i), 128'(wr_addr[wb + i]), 128'(exp_a[i]));
            chk($sformatf("enc_wr_data%0d", i), 128'(wr_data[wb + i]), 128'(exp_d[i]));
        end
        chk("enc_status_reads", 128'(stat_n - sb), 128'd8);
        chk("enc_result_reads", 128'(res_n - rb), 128'd4);
        @(posedge clk); #1;
        chk("enc_idle_after", 128'(req_ready), 128'd1);

        // Backpressure, with request inputs scrambled and held valid while busy
        resp_ready = 1'b0;
        do_req(K, P, 1'b1, 1'b1, lat);
        chk("bp_latency", 128'(lat), 128'(LAT_BP));
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(resp_valid), 128'd1);
            chk("bp_data", resp_data, C);
            chk("bp_req_ready", 128'(req_ready), 128'd0);
            @(posedge clk); #1;
        end
        chk("bp_valid_held", 128'(resp_valid), 128'd1);
        chk("bp_req_ready_held", 128'(req_ready), 128'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_req_ready_after", 128'(req_ready), 128'd1);
        chk("bp_valid_after", 128'(resp_valid), 128'd0);

        // Timeout: status stuck at 0
        stuck = 1'b1;
        wb = wr_n; sb = stat_n;
        do_req(K, P, 1'b1, 1'b0, lat);
        chk("tmo_latency", 128'(lat), 128'd25);
        chk("tmo_err", 128'(resp_err), 128'd1);
        chk("tmo_data", resp_data, 128'd0);
        chk("tmo_status_reads", 128'(stat_n - sb), 128'(TMO));
        chk("tmo_writes", 128'(wr_n - wb), 128'd6);
        @(posedge clk); #1;
        stuck = 1'b0;
        chk("tmo_idle_after", 128'(req_ready), 128'd1);

        // Reset in the middle of the block load
        req_key = K; req_block = P; req_encdec = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!(cs && we && addr == A_BLK0 + 8'd1) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("mid_reached_blk", 128'(n < 100), 128'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", 128'(cs), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_req_ready", 128'(req_ready), 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Decrypt after reset completes normally
        do_req(K, C, 1'b0, 1'b0, lat);
        chk("dec_latency", 128'(lat), 128'(LAT_FULL));
        chk("dec_data", resp_data, P);
        chk("dec_err", 128'(resp_err), 128'd0);
        @(posedge clk); #1;

`ifdef AES_MASTER_KEY_CACHE_EN
        // Same key again: key load and init skipped
        wb = wr_n;
        do_req(K, C, 1'b0, 1'b0, lat);
        chk("hit_latency", 128'(lat), 128'(LAT_HIT));
        chk("hit_data", resp_data, P);
        chk("hit_writes", 128'(wr_n - wb), 128'd6);
        chk("hit_first_blk", 128'(wr_addr[wb + 1]), 128'(A_BLK0));
        @(posedge clk); #1;
        // Changed key: full sequence
        wb = wr_n;
        do_req(K2, P, 1'b1, 1'b0, lat);
        chk("miss_latency", 128'(lat), 128'(LAT_FULL));
        chk("miss_writes", 128'(wr_n - wb), 128'd11);
        @(posedge clk); #1;
`endif

        chk("bus_idle_zero", 128'(viol_n), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
